// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types and constants for the instruction-memory program loader.
//   - state_t        : loader FSM states
//   - BYTES_PER_WORD : stream bytes per instruction word
//   - INSTR_W        : instruction word width in bits
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int INSTR_W        = 32;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler
//   Packs a byte stream into 32-bit words, first byte ending up in [31:24].
//   Ports:
//     i_clk, i_rst_n : clock, asynchronous active-low reset
//     i_clear        : drop any partial word and restart at byte 0
//     i_shift        : shift i_byte in this cycle
//     i_byte         : stream byte
//     o_word_full    : the byte shifted in this cycle completes a word
//     o_word         : assembly register (complete once the 4th byte has shifted)
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic [7:0]         i_byte,
  output logic               o_word_full,
  output logic [INSTR_W-1:0] o_word
);

  logic [1:0]         r_cnt;
  logic [INSTR_W-1:0] r_shift;

  // Byte counter wraps naturally after the last byte of a word, so the next
  // word starts at byte 0 without an explicit clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_shift) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {r_shift[INSTR_W-9:0], i_byte};
    end
  end

  // Combinational so the FSM can leave RECV on the very edge that takes byte 4.
  assign o_word_full = i_shift && (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word      = r_shift;

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Loads a program image into instruction memory from a byte stream and
//   keeps the CPU core in reset until the image is complete.
//   Ports:
//     clk_i, rst_i              : clock, asynchronous active-low reset
//     start_i, len_i            : load request and word count (IDLE/DONE only)
//     byte_valid_i, byte_data_i : incoming stream, MSB byte first
//     byte_ready_o              : a byte is accepted this cycle when valid
//     im_we_o, im_addr_o,
//     im_wdata_o                : instruction-memory write port
//     cpu_rst_o                 : active-low CPU reset, high only after a full load
//     busy_o, done_o, err_o     : status (err_o = last start had len_i too large)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [ADDR_W:0]    len_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_data_i,
  output logic               byte_ready_o,
  output logic               im_we_o,
  output logic [ADDR_W-1:0]  im_addr_o,
  output logic [INSTR_W-1:0] im_wdata_o,
  output logic               cpu_rst_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [ADDR_W:0]   LP_DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LP_LAST_ADDR = '1;

  state_t             r_state;
  logic               r_ready;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_cpu_rst;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [ADDR_W:0]    r_len;
  // One bit wider than the address so a full-depth load compares without wrapping.
  logic [ADDR_W:0]    r_word_cnt;

  logic               w_start_ok;
  logic               w_accept;
  logic               w_word_full;
  logic [INSTR_W-1:0] w_word;
  logic [ADDR_W:0]    w_word_cnt_nxt;

  assign w_start_ok     = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE))
                          && (len_i <= LP_DEPTH);
  assign w_accept       = byte_valid_i && r_ready;
  assign w_word_cnt_nxt = r_word_cnt + 1'b1;

  byte_assembler u_asm (
    .i_clk       (clk_i),
    .i_rst_n     (rst_i),
    .i_clear     (w_start_ok),
    .i_shift     (w_accept),
    .i_byte      (byte_data_i),
    .o_word_full (w_word_full),
    .o_word      (w_word)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_cpu_rst  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_len      <= '0;
      r_word_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_cpu_rst <= 1'b0;
            r_done    <= 1'b0;
            if (len_i > LP_DEPTH) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_err      <= 1'b0;
              r_len      <= len_i;
              r_word_cnt <= '0;
              r_addr     <= '0;
              if (CLEAR_ON_START) begin
                r_state <= ST_CLEAR;
                r_we    <= 1'b1;
                r_busy  <= 1'b1;
              end else if (len_i == '0) begin
                r_state   <= ST_DONE;
                r_cpu_rst <= 1'b1;
                r_done    <= 1'b1;
              end else begin
                r_state <= ST_RECV;
                r_ready <= 1'b1;
                r_busy  <= 1'b1;
              end
            end
          end
        end

        ST_CLEAR: begin
          if (r_addr == LP_LAST_ADDR) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            if (r_len == '0) begin
              r_state   <= ST_DONE;
              r_busy    <= 1'b0;
              r_cpu_rst <= 1'b1;
              r_done    <= 1'b1;
            end else begin
              r_state <= ST_RECV;
              r_ready <= 1'b1;
            end
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end

        ST_RECV: begin
          if (w_accept && w_word_full) begin
            r_state <= ST_WRITE;
            r_ready <= 1'b0;
            r_we    <= 1'b1;
            r_addr  <= r_word_cnt[ADDR_W-1:0];
          end
        end

        ST_WRITE: begin
          r_we       <= 1'b0;
          r_word_cnt <= w_word_cnt_nxt;
          if (w_word_cnt_nxt == r_len) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b1;
          end else begin
            r_state <= ST_RECV;
            r_ready <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready_o = r_ready;
  assign im_we_o      = r_we;
  assign im_addr_o    = r_addr;
  // Data is zero everywhere except WRITE, which covers the clear pass too;
  // in WRITE the assembly register already holds the finished word.
  assign im_wdata_o   = (r_state == ST_WRITE) ? w_word : '0;
  assign cpu_rst_o    = r_cpu_rst;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader. Two instances share clock and reset:
//   index 0 clears memory on start, index 1 does not. Only the selected
//   instance sees stimulus; the other has its inputs held at 0.
module tb_imem_loader;

  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstN;
  logic           selB;
  logic           drvStart;
  logic [AW:0]    drvLen;
  logic           drvValid;
  logic [7:0]     drvData;

  logic [1:0]     startV, validV;
  logic [AW:0]    lenV [2];
  logic [7:0]     byteV [2];
  logic [1:0]     readyV, weV, cpuV, busyV, doneV, errV;
  logic [AW-1:0]  addrV [2];
  logic [31:0]    dataV [2];

  // Route the single stimulus set to whichever instance is selected.
  always_comb begin
    startV       = '0;
    validV       = '0;
    lenV[0]      = '0;
    lenV[1]      = '0;
    byteV[0]     = '0;
    byteV[1]     = '0;
    startV[selB] = drvStart;
    validV[selB] = drvValid;
    lenV[selB]   = drvLen;
    byteV[selB]  = drvData;
  end

  imem_loader #(.ADDR_W(AW), .CLEAR_ON_START(1'b1)) dutClr (
    .clk_i(clk), .rst_i(rstN), .start_i(startV[0]), .len_i(lenV[0]),
    .byte_valid_i(validV[0]), .byte_data_i(byteV[0]), .byte_ready_o(readyV[0]),
    .im_we_o(weV[0]), .im_addr_o(addrV[0]), .im_wdata_o(dataV[0]),
    .cpu_rst_o(cpuV[0]), .busy_o(busyV[0]), .done_o(doneV[0]), .err_o(errV[0])
  );

  imem_loader #(.ADDR_W(AW), .CLEAR_ON_START(1'b0)) dutNoClr (
    .clk_i(clk), .rst_i(rstN), .start_i(startV[1]), .len_i(lenV[1]),
    .byte_valid_i(validV[1]), .byte_data_i(byteV[1]), .byte_ready_o(readyV[1]),
    .im_we_o(weV[1]), .im_addr_o(addrV[1]), .im_wdata_o(dataV[1]),
    .cpu_rst_o(cpuV[1]), .busy_o(busyV[1]), .done_o(doneV[1]), .err_o(errV[1])
  );

  // Reference model: the ordered list of writes a load must produce, plus the
  // memory image it must leave behind.
  logic [AW+31:0] expQ [$];
  logic [31:0]    expMem [2][DEPTH];
  logic [31:0]    capMem [2][DEPTH];
  logic [31:0]    words [DEPTH];

  int  nChecks = 0;
  int  nFails  = 0;
  int  ncyc    = 0;
  int  lastWe  = 0;
  int  riseCyc = 0;
  logic prevCpu = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe the selected instance at the falling edge, then return
  // just after the next rising edge so the caller can drive fresh inputs.
  task automatic tick();
    logic [AW+31:0] e;
    @(negedge clk);
    ncyc++;
    if (weV[selB]) begin
      lastWe = ncyc;
      capMem[selB][addrV[selB]] = dataV[selB];
      checkOutput("we_while_done", {63'd0, doneV[selB]}, 64'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_we", {63'd0, weV[selB]}, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("we_addr", {59'd0, addrV[selB]}, {59'd0, e[AW+31:32]});
        checkOutput("we_data", {32'd0, dataV[selB]}, {32'd0, e[31:0]});
      end
    end
    if (cpuV[selB] && !prevCpu) riseCyc = ncyc;
    prevCpu = cpuV[selB];
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad(input int len);
    drvStart = 1'b1;
    drvLen   = (AW+1)'(len);
    tick();
    drvStart = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    bit acc = 1'b0;
    drvValid = 1'b0;
    repeat (gap) tick();
    drvValid = 1'b1;
    drvData  = b;
    for (int t = 0; t < 100; t++) begin
      if (readyV[selB]) begin
        tick();
        acc = 1'b1;
        break;
      end
      tick();
    end
    drvValid = 1'b0;
    if (!acc) checkOutput("byte_timeout", {63'd0, acc}, 64'd1);
  endtask

  // Full load of words[0..n-1] into the selected instance. gap < 0 gives a
  // random 0..2 idle cycles before each byte.
  task automatic applyStimulus(input int n, input int gap);
    bit clr = (selB == 1'b0);
    int g;
    expQ.delete();
    if (clr) begin
      for (int a = 0; a < DEPTH; a++) begin
        expQ.push_back({AW'(a), 32'd0});
        expMem[selB][a] = 32'd0;
      end
    end
    for (int i = 0; i < n; i++) begin
      expQ.push_back({AW'(i), words[i]});
      expMem[selB][i] = words[i];
    end
    startLoad(n);
    checkOutput("first_cycle_we", {63'd0, weV[selB]}, {63'd0, clr});
    checkOutput("cpu_rst_on_start", {63'd0, cpuV[selB]}, 64'd0);
    checkOutput("busy_on_start", {63'd0, busyV[selB]}, 64'd1);
    checkOutput("err_cleared", {63'd0, errV[selB]}, 64'd0);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        sendByte(words[i][31-8*b -: 8], g);
      end
      checkOutput("we_after_4th", {63'd0, weV[selB]}, 64'd1);
      checkOutput("ready_in_write", {63'd0, readyV[selB]}, 64'd0);
      tick();
      checkOutput("ready_again", {63'd0, readyV[selB]}, {63'd0, (i < n - 1)});
    end
    tick();
    for (int t = 0; t < 200 && !doneV[selB]; t++) tick();
    checkOutput("done", {63'd0, doneV[selB]}, 64'd1);
    checkOutput("cpu_rst_released", {63'd0, cpuV[selB]}, 64'd1);
    checkOutput("busy_after", {63'd0, busyV[selB]}, 64'd0);
    checkOutput("pending_writes", 64'(expQ.size()), 64'd0);
    checkOutput("cpu_rst_delay", 64'(riseCyc - lastWe), 64'd1);
  endtask

  task automatic compareMem();
    for (int a = 0; a < DEPTH; a++)
      checkOutput($sformatf("mem%0d_%0d", selB, a), {32'd0, capMem[selB][a]}, {32'd0, expMem[selB][a]});
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < DEPTH; a++) begin
        expMem[d][a] = 32'hDEAD_BEEF;
        capMem[d][a] = 32'hDEAD_BEEF;
      end
    selB = 1'b0; drvStart = 1'b0; drvLen = '0; drvValid = 1'b0; drvData = '0;
    rstN = 1'b0;

    // Reset held while start toggles: everything stays quiet.
    for (int c = 0; c < 3; c++) begin
      drvStart = ~drvStart;
      drvLen   = 2;
      tick();
      checkOutput("reset_flags", {52'd0, readyV, weV, cpuV, busyV, doneV, errV}, 64'd0);
      checkOutput("reset_data", {22'd0, addrV[0], addrV[1], dataV[0] | dataV[1]}, 64'd0);
    end
    drvStart = 1'b0;
    rstN = 1'b1;
    tick();
    tick();

    // Known program, no gaps.
    words[0] = 32'h8C01_0004;
    words[1] = 32'h2042_0005;
    applyStimulus(2, 0);
    compareMem();

    // Same program with three idle cycles before every byte.
    applyStimulus(2, 3);
    compareMem();

    // Random program, random gaps.
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    applyStimulus(5, -1);
    compareMem();

    // Oversized length: error, no writes, CPU held.
    expQ.delete();
    startLoad(DEPTH + 1);
    checkOutput("err_set", {63'd0, errV[0]}, 64'd1);
    checkOutput("err_busy", {63'd0, busyV[0]}, 64'd0);
    checkOutput("err_cpu_rst", {63'd0, cpuV[0]}, 64'd0);
    checkOutput("err_done", {63'd0, doneV[0]}, 64'd0);
    repeat (5) tick();
    checkOutput("err_sticky", {63'd0, errV[0]}, 64'd1);
    words[0] = $urandom;
    applyStimulus(1, 0);
    compareMem();

    // Full-depth load without clear on the second instance.
    selB = 1'b1;
    prevCpu = cpuV[1];
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    applyStimulus(DEPTH, -1);
    checkOutput("last_addr", {59'd0, addrV[1]}, 64'(DEPTH - 1));
    compareMem();

    // Reload from DONE, then reset after two bytes of the first word.
    expQ.delete();
    words[0] = $urandom;
    startLoad(3);
    checkOutput("reload_cpu_rst", {63'd0, cpuV[1]}, 64'd0);
    checkOutput("reload_done", {63'd0, doneV[1]}, 64'd0);
    sendByte(words[0][31:24], 0);
    sendByte(words[0][23:16], 0);
    rstN = 1'b0;
    #1;
    checkOutput("abort_busy", {63'd0, busyV[1]}, 64'd0);
    checkOutput("abort_ready", {63'd0, readyV[1]}, 64'd0);
    checkOutput("abort_cpu_rst", {63'd0, cpuV[1]}, 64'd0);
    tick();
    tick();
    rstN = 1'b1;
    repeat (4) tick();
    checkOutput("after_abort_cpu_rst", {63'd0, cpuV[1]}, 64'd0);
    checkOutput("after_abort_we", {63'd0, weV[1]}, 64'd0);
    compareMem();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
